// File: rtl/reset_sync_seq.sv
// reset_sync_seq: reset receiver that turns a raw asynchronous reset into staggered per-domain resets.
// Assertion is asynchronous. Release is synchronized to clk, held for HOLD_CYCLES, then sequenced one output at a time.
// A synchronous software reset is accepted once release is complete.
// Ports:
//   clk          - single clock, rising edge
//   arst         - asynchronous active-high reset
//   sw_rst_req   - synchronous software reset request (honoured only once release is complete)
//   rst_out      - NUM_OUT active-high resets, released in index order
//   rst_done     - high once every rst_out bit is released
//   rst_evt_cnt  - completed release sequences since last arst, saturating at 255
module reset_sync_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned STAGGER     = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               rst_done,
    output logic [7:0]         rst_evt_cnt
);

    // One counter covers both the hold and the stagger intervals.
    localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_SWHOLD  = 3'd4
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   srst;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_OUT-1:0]     rst_out_q, rst_out_d;
    logic                   rst_done_q, rst_done_d;
    logic [7:0]             evt_q, evt_d;

    // Deassertion synchronizer: set asynchronously, shifts zeros in while arst is low.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign srst = sync_q[SYNC_STAGES-1];

    // State and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            rst_out_q  <= '1;
            rst_done_q <= 1'b0;
            evt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            rst_done_q <= rst_done_d;
            evt_q      <= evt_d;
        end
    end

    // Next-state logic. Releasing a bit shifts a zero in from the bottom,
    // so released bits stay low and release proceeds in index order.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_out_d  = rst_out_q;
        rst_done_d = rst_done_q;
        evt_d      = evt_q;

        unique case (state_q)
            ST_ASSERT: begin
                cnt_d = '0;
                if (!srst) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD, ST_SWHOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_RELEASE;
                    cnt_d     = '0;
                    rst_out_d = NUM_OUT'(rst_out_q << 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!rst_out_q[NUM_OUT-1]) begin
                    // Last bit dropped on the previous edge: report completion.
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    rst_done_d = 1'b1;
                    if (evt_q != 8'hFF) begin
                        evt_d = evt_q + 8'd1;
                    end
                end else if (cnt_q == STAG_LAST) begin
                    cnt_d     = '0;
                    rst_out_d = NUM_OUT'(rst_out_q << 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                cnt_d = '0;
                if (sw_rst_req) begin
                    state_d    = ST_SWHOLD;
                    rst_out_d  = '1;
                    rst_done_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    assign rst_out     = rst_out_q;
    assign rst_done    = rst_done_q;
    assign rst_evt_cnt = evt_q;

endmodule
